// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: rv32i word/opcode types, fetch buffer entry and fetch FSM states
package fetch_unit_pkg;
  typedef logic [31:0] rv32i_word;
  typedef enum logic [6:0] {
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_jal   = 7'b1101111,
    op_jalr  = 7'b1100111,
    op_br    = 7'b1100011,
    op_load  = 7'b0000011,
    op_store = 7'b0100011,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011
  } rv32i_opcode;
  typedef struct packed {
    rv32i_word pc;
    rv32i_word instr;
    rv32i_word pred_pc;
  } fetch_entry_t;
  typedef enum logic [1:0] {IDLE, REQ, FLUSH_WAIT} fetch_state_t;
  function automatic rv32i_word jal_imm(input rv32i_word i);
    return {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
  endfunction
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO of fetch_entry_t with push/pop/clear, active-low sync reset
module fetch_fifo
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  fetch_entry_t             din_i,
  input  logic                     pop_i,
  input  logic                     clear_i,
  output fetch_entry_t             dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  fetch_entry_t mem_q [DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [AW:0] cnt_q;
  logic do_push, do_pop;
  assign do_pop = pop_i && cnt_q != '0;
  assign do_push = push_i && (cnt_q != FULL || do_pop);
  always_ff @(posedge clk) begin
    if (!rst || clear_i) begin
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (rst && !clear_i && do_push) mem_q[wr_q] <= din_i;
  end
  assign dout_o = mem_q[rd_q];
  assign full_o = cnt_q == FULL;
  assign empty_o = cnt_q == '0;
  assign count_o = cnt_q;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC/fetch FSM, fetch buffer and redirect flush; FETCH_JAL_PREDICT_EN enables JAL target prediction
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter rv32i_word RESET_PC = 32'h40000060,
  parameter int FBUF_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_mem_resp,
  input  logic [31:0] instr_mem_rdata,
  output logic        instr_read,
  output logic [31:0] instr_mem_address,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        iq_ready,
  output logic        fetch_valid,
  output logic [31:0] fetch_instr,
  output logic [31:0] fetch_pc,
  output logic [31:0] fetch_pred_pc
);
  localparam int CW = $clog2(FBUF_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FBUF_DEPTH);
  fetch_state_t state_q;
  rv32i_word pc_q, stale_q, pred_pc, target;
  logic push, pop, empty, full;
  logic [CW-1:0] count, count_d;
  fetch_entry_t entry_in, head;
`ifdef FETCH_JAL_PREDICT_EN
  assign pred_pc = instr_mem_rdata[6:0] == op_jal ? pc_q + jal_imm(instr_mem_rdata) : pc_q + 32'd4;
`else
  assign pred_pc = pc_q + 32'd4;
`endif
  assign target = redirect_pc & ~32'd3;
  assign push = state_q == REQ && instr_mem_resp && !redirect_valid;
  assign pop = !empty && iq_ready && !redirect_valid;
  assign count_d = count + CW'(push) - CW'(pop);
  assign entry_in = '{pc: pc_q, instr: instr_mem_rdata, pred_pc: pred_pc};
  fetch_fifo #(.DEPTH(FBUF_DEPTH)) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push_i (push),
    .din_i  (entry_in),
    .pop_i  (pop),
    .clear_i(redirect_valid),
    .dout_o (head),
    .full_o (full),
    .empty_o(empty),
    .count_o(count)
  );
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      pc_q <= RESET_PC;
      stale_q <= RESET_PC;
    end else if (state_q == FLUSH_WAIT) begin
      if (redirect_valid) pc_q <= target;
      if (instr_mem_resp) state_q <= REQ;
    end else if (redirect_valid) begin
      pc_q <= target;
      stale_q <= pc_q;
      state_q <= state_q == REQ && !instr_mem_resp ? FLUSH_WAIT : REQ;
    end else if (state_q == IDLE) begin
      if (!full || pop) state_q <= REQ;
    end else if (instr_mem_resp) begin
      pc_q <= pred_pc;
      state_q <= count_d < DEPTH_C ? REQ : IDLE;
    end
  end
  assign instr_read = state_q != IDLE;
  assign instr_mem_address = state_q == FLUSH_WAIT ? stale_q : pc_q;
  assign fetch_valid = !empty;
  assign fetch_instr = head.instr;
  assign fetch_pc = head.pc;
  assign fetch_pred_pc = head.pred_pc;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed-vector bench for fetch_unit with a variable-latency instruction memory model
module tb_fetch_unit;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic instr_mem_resp = 1'b0;
  logic [31:0] instr_mem_rdata = '0;
  logic instr_read;
  logic [31:0] instr_mem_address;
  logic redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic iq_ready = 1'b1;
  logic fetch_valid;
  logic [31:0] fetch_instr, fetch_pc, fetch_pred_pc;
  logic w_read, w_valid;
  logic [31:0] w_addr, w_instr, w_pc, w_pred;
  int n_vec = 0;
  int n_err = 0;
  int lat = 1;
  int wcnt = 0;
  int nresp = 0;
  bit jal_mode = 1'b0;
`ifdef FETCH_JAL_PREDICT_EN
  localparam logic [31:0] JAL_NEXT = 32'h40000080;
`else
  localparam logic [31:0] JAL_NEXT = 32'h40000064;
`endif
  always #5 clk = ~clk;
  fetch_unit u_dut (
    .clk              (clk),
    .rst              (rst),
    .instr_mem_resp   (instr_mem_resp),
    .instr_mem_rdata  (instr_mem_rdata),
    .instr_read       (instr_read),
    .instr_mem_address(instr_mem_address),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .iq_ready         (iq_ready),
    .fetch_valid      (fetch_valid),
    .fetch_instr      (fetch_instr),
    .fetch_pc         (fetch_pc),
    .fetch_pred_pc    (fetch_pred_pc)
  );
  fetch_unit #(.RESET_PC(32'hFFFFFFF8)) u_wrap (
    .clk              (clk),
    .rst              (rst),
    .instr_mem_resp   (w_read),
    .instr_mem_rdata  (32'h00000013),
    .instr_read       (w_read),
    .instr_mem_address(w_addr),
    .redirect_valid   (1'b0),
    .redirect_pc      (32'h0),
    .iq_ready         (1'b1),
    .fetch_valid      (w_valid),
    .fetch_instr      (w_instr),
    .fetch_pc         (w_pc),
    .fetch_pred_pc    (w_pred)
  );
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (jal_mode && a == 32'h40000060) ? 32'h0200006F : ((a << 5) | 32'h13);
  endfunction
  always @(negedge clk) begin
    if (!instr_read) wcnt = 0;
    instr_mem_resp = instr_read && wcnt >= lat - 1;
    instr_mem_rdata = instr_mem_resp ? mem_word(instr_mem_address) : 32'hDEADBEEF;
    if (instr_read) wcnt = instr_mem_resp ? 0 : wcnt + 1;
  end
  always @(posedge clk) if (instr_read && instr_mem_resp) nresp <= nresp + 1;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic do_reset();
    rst = 1'b0;
    step(2);
    rst = 1'b1;
    step(1);
    nresp = 0;
  endtask
  initial begin
    step(2);
    check("rst_read", 32'(instr_read), 32'd0);
    check("rst_addr", instr_mem_address, 32'h40000060);
    check("rst_valid", 32'(fetch_valid), 32'd0);
    check("rst_wrap_addr", w_addr, 32'hFFFFFFF8);
    do_reset();
    check("a_read", 32'(instr_read), 32'd1);
    check("a_addr0", instr_mem_address, 32'h40000060);
    check("a_valid0", 32'(fetch_valid), 32'd0);
    check("w_addr0", w_addr, 32'hFFFFFFF8);
    step(1);
    check("a_addr1", instr_mem_address, 32'h40000064);
    check("a_valid1", 32'(fetch_valid), 32'd1);
    check("a_pc1", fetch_pc, 32'h40000060);
    check("a_pred1", fetch_pred_pc, 32'h40000064);
    check("a_instr1", fetch_instr, mem_word(32'h40000060));
    check("w_addr1", w_addr, 32'hFFFFFFFC);
    check("w_pc1", w_pc, 32'hFFFFFFF8);
    check("w_pred1", w_pred, 32'hFFFFFFFC);
    step(1);
    check("a_addr2", instr_mem_address, 32'h40000068);
    check("a_pc2", fetch_pc, 32'h40000064);
    check("w_addr2", w_addr, 32'h00000000);
    check("w_pc2", w_pc, 32'hFFFFFFFC);
    check("w_pred2", w_pred, 32'h00000000);
    check("w_instr2", w_instr, 32'h00000013);
    check("w_valid2", 32'(w_valid), 32'd1);
    iq_ready = 1'b0;
    do_reset();
    step(10);
    check("b_nresp", 32'(nresp), 32'd4);
    check("b_read", 32'(instr_read), 32'd0);
    check("b_valid", 32'(fetch_valid), 32'd1);
    check("b_pc", fetch_pc, 32'h40000060);
    iq_ready = 1'b1;
    step(1);
    check("b_reread", 32'(instr_read), 32'd1);
    check("b_readdr", instr_mem_address, 32'h40000070);
    check("b_pc_pop", fetch_pc, 32'h40000064);
    lat = 5;
    do_reset();
    step(1);
    redirect_valid = 1'b1;
    redirect_pc = 32'h40000103;
    step(1);
    redirect_valid = 1'b0;
    check("c_read", 32'(instr_read), 32'd1);
    check("c_stale2", instr_mem_address, 32'h40000060);
    step(2);
    check("c_stale4", instr_mem_address, 32'h40000060);
    step(1);
    check("c_newaddr", instr_mem_address, 32'h40000100);
    check("c_newread", 32'(instr_read), 32'd1);
    check("c_dropped", 32'(fetch_valid), 32'd0);
    step(4);
    check("c_wait", 32'(fetch_valid), 32'd0);
    step(1);
    check("c_valid", 32'(fetch_valid), 32'd1);
    check("c_pc", fetch_pc, 32'h40000100);
    lat = 1;
    iq_ready = 1'b0;
    do_reset();
    step(3);
    check("d_valid_pre", 32'(fetch_valid), 32'd1);
    check("d_addr_pre", instr_mem_address, 32'h4000006C);
    iq_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h40000200;
    step(1);
    redirect_valid = 1'b0;
    check("d_flushed", 32'(fetch_valid), 32'd0);
    check("d_addr", instr_mem_address, 32'h40000200);
    check("d_read", 32'(instr_read), 32'd1);
    step(1);
    check("d_pc", fetch_pc, 32'h40000200);
    jal_mode = 1'b1;
    do_reset();
    step(1);
    check("f_instr", fetch_instr, 32'h0200006F);
    check("f_pred", fetch_pred_pc, JAL_NEXT);
    check("f_addr", instr_mem_address, JAL_NEXT);
    step(1);
    check("f_pc", fetch_pc, JAL_NEXT);
    check("f_addr2", instr_mem_address, JAL_NEXT + 32'd4);
    jal_mode = 1'b0;
    lat = 5;
    do_reset();
    step(1);
    check("g_read_pre", 32'(instr_read), 32'd1);
    rst = 1'b0;
    step(1);
    check("g_read", 32'(instr_read), 32'd0);
    check("g_addr", instr_mem_address, 32'h40000060);
    check("g_valid", 32'(fetch_valid), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
